uart_apb_tx_ctrl: RTL
=====================

Name: uart_apb_tx_ctrl

Overview:
APB master controller that sequences the 16550 UART APB slave used as the system console. After reset it programs the line-control and divisor registers. It then drains an internal byte FIFO, fed by a valid/ready producer, by polling LSR.THRE and writing THR one byte per ready poll. The block sits between the console producer (CPU-side debug port) and the uart APB slave.

Parameters:
BASE_ADDR, 32'h1000_0000, UART base address; register offsets are added to it.
DIVISOR, 16'h0001, baud divisor; DLL gets [7:0], DLM gets [15:8].
LCR_VAL, 8'h03, final LCR value (8N1).
FIFO_DEPTH, 8, TX byte FIFO entries; must be a power of 2, at least 2.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
tx_valid  in  1  producer has a byte
tx_data  in  8  byte to transmit
tx_ready  out  1  FIFO can accept; equals !full
init_done  out  1  high once the init sequence completes
err  out  1  sticky; set by any pslverr
out_psel  out  1  APB select
out_penable  out  1  APB enable
out_paddr  out  32  APB address
out_pwrite  out  1  APB write
out_pwdata  out  32  write data, byte replicated {4{b}}
out_pstrb  out  4  one-hot lane = 1 << paddr[1:0]; 4'b0000 on reads
out_pprot  out  3  constant 3'b000
out_prdata  in  32  read data
out_pready  in  1  slave ready
out_pslverr  in  1  slave error

Behaviour:
- Clock is named clock. Reset is named reset, and it is synchronous and active-low: the block is in reset while reset==0, sampled at the posedge of clock.
- In reset: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, init_done=0, err=0, FIFO empty, tx_ready=0, FSM=INIT0.
- tx_ready = !full while out of reset.
- The FIFO accepts a push when tx_valid && tx_ready. Pointers wrap modulo FIFO_DEPTH. A count of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- Push and pop in the same cycle: count is unchanged and both transfers happen.
- APB transfer protocol:
  - SETUP cycle: psel=1, penable=0, with address, data and strobe valid.
  - ACCESS cycles: psel=1, penable=1, held until pready=1.
  - The transfer completes on the ACCESS cycle where pready=1. In the next cycle psel=0, except where the FSM goes straight to another SETUP.
  - Address, data and strobe are stable from SETUP through completion.
- FSM states and transitions (each W/R state is a full SETUP+ACCESS transfer; advance occurs on completion):
  - INIT0: write LCR (+3) = 8'h83, setting DLAB -> INIT1.
  - INIT1: write DLL (+0) = DIVISOR[7:0] -> INIT2.
  - INIT2: write DLM (+1) = DIVISOR[15:8] -> INIT3.
  - INIT3: write LCR (+3) = LCR_VAL -> IDLE, and init_done goes to 1 in the same cycle.
  - IDLE: stays while the FIFO is empty; otherwise -> POLL with SETUP on the next cycle. This gives a minimum 1 idle cycle between transfers.
  - POLL: read LSR (+5). The slave returns the byte replicated, so the block uses prdata[15:8] (lane paddr[1:0]=1). If bit5 (THRE)=1 -> SEND, otherwise -> POLL again after 1 idle cycle.
  - SEND: write THR (+0) = FIFO head. On completion pop the head -> IDLE.
- The first init SETUP occurs in the first cycle after reset goes high.
- The FIFO accepts pushes during init; bytes are held until init_done.
- pslverr on a completing transfer:
  - err is set to 1 and stays set until reset.
  - The FSM advances as if the transfer succeeded; a SEND byte still pops, i.e. it is dropped.
  - A POLL that errors is treated as THRE=0.
- Reset asserted mid-transfer: psel and penable drop in the next cycle, the FIFO is flushed, and the whole init sequence reruns.
- Wait states are unbounded; there is no timeout.

Test Plan:
- Reset low for 3 cycles, then high, pready tied 1, DIVISOR=16'h0001. Required APB writes in order: 0x10000003=0x83, 0x10000000=0x01, 0x10000001=0x00, 0x10000003=0x03. Each is 2 cycles. init_done rises with the completion of the 4th write. tx_ready=1.
- Push 8'h41 with prdata=32'h60606060 (THRE=1). Required: read 0x10000005, then a write to 0x10000000 with pwdata=32'h41414141 and pstrb=4'b0001. FIFO ends empty.
- Push 8'h42 and return THRE=0 (32'h00000000) for 3 polls, then 32'h20202020. Required: exactly 4 LSR reads, then 1 THR write of 0x42.
- Hold tx_valid high with THRE=0. Required: tx_ready falls after 8 accepted bytes; a push and pop in the same cycle at count 8 do not occur. After THRE=1 the bytes emerge in order with no loss or duplication.
- Insert 3 wait states (pready=0) on a THR write. Required: psel, penable, paddr and pwdata are stable for all 4 ACCESS cycles, and the pop happens only on completion.
- Assert pslverr on the INIT2 write. Required: err=1 sticky and init continues to INIT3. Then pull reset low mid-POLL. Required: psel=0 next cycle, FIFO empty, and init restarts with LCR=0x83.

Source files
------------

// File: rtl/uart_apb_tx_ctrl.sv
// uart_apb_tx_ctrl: APB master that initialises a 16550 console UART
// (LCR/DLL/DLM/LCR), then drains a small TX byte FIFO into THR, polling
// LSR.THRE before every byte.
module uart_apb_tx_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter logic [15:0] DIVISOR    = 16'h0001,
   parameter logic [7:0]  LCR_VAL    = 8'h03,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tx_valid,
   input  logic [7:0]  tx_data,
   output logic        tx_ready,
   output logic        init_done,
   output logic        err,
   output logic        out_psel,
   output logic        out_penable,
   output logic [31:0] out_paddr,
   output logic        out_pwrite,
   output logic [31:0] out_pwdata,
   output logic [3:0]  out_pstrb,
   output logic [2:0]  out_pprot,
   input  logic [31:0] out_prdata,
   input  logic        out_pready,
   input  logic        out_pslverr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   // UART register offsets from BASE_ADDR
   localparam logic [2:0] OFS_THR = 3'd0;   // also DLL while DLAB=1
   localparam logic [2:0] OFS_DLM = 3'd1;
   localparam logic [2:0] OFS_LCR = 3'd3;
   localparam logic [2:0] OFS_LSR = 3'd5;

   typedef enum logic [2:0] {INIT0, INIT1, INIT2, INIT3, IDLE, POLL, SEND} state_t;

   // What the current state wants on the bus
   typedef struct packed {
      logic [2:0] ofs;
      logic       wr;
      logic [7:0] wbyte;
   } apb_req_t;

   state_t          state, state_d;
   logic            psel_q, psel_d;
   logic            penable_q, penable_d;
   logic            init_done_q, err_q;
   logic            done_set, pop, push;
   apb_req_t        req;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic            full, empty;
   logic [7:0]      head;

   // LSR comes back byte-replicated; its copy in lane 1 matches paddr[1:0]=1
   logic [7:0]      lsr;
   logic            thre;
   logic            unused_prdata;

   assign lsr           = out_prdata[15:8];
   assign thre          = lsr[5];
   assign unused_prdata = ^{out_prdata[31:16], out_prdata[7:0], lsr[7:6], lsr[4:0]};

   // ---------------- TX FIFO ----------------
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign tx_ready = reset & ~full;
   assign push     = tx_valid & tx_ready;
   assign head     = mem[rd_ptr];

   // Storage has no reset; only pointers and count define contents
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // Pointers and occupancy; simultaneous push/pop leaves count unchanged
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // ---------------- APB request decode ----------------
   // Per-state register target and write byte
   always_comb begin
      req = '{ofs: OFS_THR, wr: 1'b0, wbyte: 8'h00};
      case (state)
         INIT0:   req = '{ofs: OFS_LCR, wr: 1'b1, wbyte: 8'h83};
         INIT1:   req = '{ofs: OFS_THR, wr: 1'b1, wbyte: DIVISOR[7:0]};
         INIT2:   req = '{ofs: OFS_DLM, wr: 1'b1, wbyte: DIVISOR[15:8]};
         INIT3:   req = '{ofs: OFS_LCR, wr: 1'b1, wbyte: LCR_VAL};
         POLL:    req = '{ofs: OFS_LSR, wr: 1'b0, wbyte: 8'h00};
         SEND:    req = '{ofs: OFS_THR, wr: 1'b1, wbyte: head};
         default: req = '{ofs: OFS_THR, wr: 1'b0, wbyte: 8'h00};
      endcase
   end

   // Bus fields are zero outside a transfer; state and head are frozen
   // during a transfer so these hold steady from SETUP to completion.
   assign out_psel    = psel_q;
   assign out_penable = penable_q;
   assign out_paddr   = psel_q ? (BASE_ADDR + {29'd0, req.ofs}) : 32'h0;
   assign out_pwrite  = psel_q & req.wr;
   assign out_pwdata  = out_pwrite ? {4{req.wbyte}} : 32'h0;
   assign out_pstrb   = out_pwrite ? (4'b0001 << out_paddr[1:0]) : 4'b0000;
   assign out_pprot   = 3'b000;
   assign init_done   = init_done_q;
   assign err         = err_q;

   // ---------------- FSM ----------------
   // Next state plus SETUP/ACCESS phase; advance only on pready
   always_comb begin
      state_d   = state;
      psel_d    = psel_q;
      penable_d = penable_q;
      pop       = 1'b0;
      done_set  = 1'b0;
      if (!psel_q) begin
         if (state == IDLE) begin
            if (!empty) begin
               state_d = POLL;
               psel_d  = 1'b1;
            end
         end else begin
            psel_d = 1'b1;      // INIT0 straight out of reset
         end
      end else if (!penable_q) begin
         penable_d = 1'b1;
      end else if (out_pready) begin
         penable_d = 1'b0;
         case (state)
            INIT0: state_d = INIT1;
            INIT1: state_d = INIT2;
            INIT2: state_d = INIT3;
            INIT3: begin
               state_d  = IDLE;
               psel_d   = 1'b0;
               done_set = 1'b1;
            end
            // an erroring poll counts as "not empty yet"
            POLL: begin
               if (thre && !out_pslverr) begin
                  state_d = SEND;
               end else begin
                  state_d = IDLE;
                  psel_d  = 1'b0;
               end
            end
            // byte leaves the FIFO even if the write errored
            SEND: begin
               state_d = IDLE;
               psel_d  = 1'b0;
               pop     = 1'b1;
            end
            default: begin
               state_d = IDLE;
               psel_d  = 1'b0;
            end
         endcase
      end
   end

   // State register, init flag and sticky error
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= INIT0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         init_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         init_done_q <= init_done_q | done_set;
         err_q       <= err_q | (psel_q & penable_q & out_pready & out_pslverr);
      end
   end

endmodule
